// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate unit.
// No logic; types only.
// No flow control.
package imm_pkg;

    // Immediate format select carried alongside each decoded instruction.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b011,
        IMM_U     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_ZIMM  = 3'b110,
        IMM_RSVD  = 3'b111
    } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate format mux: Instr + ImmSrc -> sign/zero-extended immediate.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module imm_decode
    import imm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      Instr,
    input  imm_src_e         ImmSrc,
    output logic [WIDTH-1:0] ImmOp,
    output logic             IllegalImm
);

    // The opcode field never contributes to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^Instr[6:0];

    // Format select; signed casts to WIDTH replicate Instr[31] into the upper bits.
    always_comb begin
        ImmOp      = '0;
        IllegalImm = 1'b0;
        case (ImmSrc)
            IMM_I:     ImmOp = WIDTH'($signed(Instr[31:20]));
            IMM_S:     ImmOp = WIDTH'($signed({Instr[31:25], Instr[11:7]}));
            IMM_B:     ImmOp = WIDTH'($signed({Instr[31], Instr[7], Instr[30:25],
                                               Instr[11:8], 1'b0}));
            IMM_J:     ImmOp = WIDTH'($signed({Instr[31], Instr[19:12], Instr[20],
                                               Instr[30:21], 1'b0}));
            IMM_U:     ImmOp = WIDTH'($signed({Instr[31:12], 12'b0}));
            IMM_SHAMT: begin
                // RV64 shift amounts carry one extra bit.
                if (WIDTH == 64) ImmOp = WIDTH'(Instr[25:20]);
                else             ImmOp = WIDTH'(Instr[24:20]);
            end
            IMM_ZIMM:  ImmOp = WIDTH'(Instr[19:15]);
            IMM_RSVD:  IllegalImm = 1'b1;
            default:   IllegalImm = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Elastic immediate-extend pipeline: decodes the immediate and precomputes PC + imm.
// Latency: STAGES cycles accept-to-OutValid with no backpressure; 1 result per cycle.
// Backpressure: OutReady=0 freezes the last stage; bubbles collapse; InReady drops when full or on Flush.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      Instr,
    input  logic [WIDTH-1:0] PC,
    input  imm_src_e         ImmSrc,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ImmOp,
    output logic [WIDTH-1:0] TargetOp,
    output logic             IllegalImm
);

    // aux holds PC until the adder stage, TargetOp afterwards.
    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] aux;
        logic             ill;
    } stage_t;

    logic [WIDTH-1:0]  dec_imm;
    logic              dec_ill;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] in_vld;
    stage_t            pay    [STAGES];
    stage_t            in_pay [STAGES];

    imm_decode #(.WIDTH(WIDTH)) u_decode (
        .Instr      (Instr),
        .ImmSrc     (ImmSrc),
        .ImmOp      (dec_imm),
        .IllegalImm (dec_ill)
    );

    // Advance chain from the output back: a stage moves if empty or if its successor moves.
    always_comb begin
        logic nxt;
        adv = '0;
        nxt = OutReady;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld[k] || nxt;
            nxt    = adv[k];
        end
    end

    assign InReady = !Flush && adv[0];

    // Stage inputs: stage 0 from the decoder; the adder sits in front of stage 1 when STAGES=2.
    always_comb begin
        in_vld[0]     = InValid && !Flush;
        in_pay[0].imm = dec_imm;
        in_pay[0].aux = (STAGES == 1) ? (PC + dec_imm) : PC;
        in_pay[0].ill = dec_ill;
        for (int k = 1; k < STAGES; k++) begin
            in_vld[k]     = vld[k-1];
            in_pay[k].imm = pay[k-1].imm;
            in_pay[k].aux = (k == 1) ? (pay[k-1].imm + pay[k-1].aux) : pay[k-1].aux;
            in_pay[k].ill = pay[k-1].ill;
        end
    end

    // Stage registers; Flush only clears valids, payload is left as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                pay[k] <= '0;
            end
        end else if (Flush) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    vld[k] <= in_vld[k];
                    if (in_vld[k]) pay[k] <= in_pay[k];
                end
            end
        end
    end

    assign OutValid   = vld[STAGES-1];
    assign ImmOp      = pay[STAGES-1].imm;
    assign TargetOp   = pay[STAGES-1].aux;
    assign IllegalImm = pay[STAGES-1].ill;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench over four configurations (WIDTH 32/64 x STAGES 2/1) sharing one stimulus stream.
// Latency: checked exactly when no stall preceded the accept, otherwise only a lower bound.
// Backpressure: OutReady/Flush driven directed and randomly; InReady checked against occupancy.
module tb_imm_extend_pipe;
    import imm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    imm_src_e    imm_src = IMM_I;

    logic        o_rdy_in [4];
    logic        o_vld    [4];
    logic [63:0] o_imm    [4];
    logic [63:0] o_tgt    [4];
    logic        o_ill    [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int W = (g >= 2) ? 64 : 32;
        localparam int S = (g % 2 == 0) ? 2 : 1;
        logic [W-1:0] imm_o;
        logic [W-1:0] tgt_o;
        logic         ir;
        logic         ov;
        logic         ill;
        imm_extend_pipe #(.WIDTH(W), .STAGES(S)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .Flush      (flush),
            .InValid    (in_valid),
            .InReady    (ir),
            .Instr      (instr),
            .PC         (pc[W-1:0]),
            .ImmSrc     (imm_src),
            .OutValid   (ov),
            .OutReady   (out_ready),
            .ImmOp      (imm_o),
            .TargetOp   (tgt_o),
            .IllegalImm (ill)
        );
        assign o_rdy_in[g] = ir;
        assign o_vld[g]    = ov;
        assign o_imm[g]    = 64'(imm_o);
        assign o_tgt[g]    = 64'(tgt_o);
        assign o_ill[g]    = ill;
    end

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t sbq [4][$];
    int   total = 0;
    int   bad = 0;

    function automatic int wid(int g);
        return (g >= 2) ? 64 : 32;
    endfunction

    function automatic int stg(int g);
        return (g % 2 == 0) ? 2 : 1;
    endfunction

    // Reference: immediate as a signed integer value, then reduced modulo 2^w.
    function automatic exp_t ref_calc(logic [31:0] ins, imm_src_e src, int w, logic [63:0] p);
        exp_t        r;
        longint      v;
        logic [63:0] mask;
        r.ill = 1'b0;
        case (src)
            IMM_I:     v = longint'($signed(ins[31:20]));
            IMM_S:     v = longint'($signed({ins[31:25], ins[11:7]}));
            IMM_B:     v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            IMM_J:     v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            IMM_U:     v = longint'($signed(ins[31:12])) * 4096;
            IMM_SHAMT: v = (w == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
            IMM_ZIMM:  v = longint'(ins[19:15]);
            default: begin
                v     = 0;
                r.ill = 1'b1;
            end
        endcase
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        r.imm = 64'(v) & mask;
        r.tgt = (p + 64'(v)) & mask;
        r.acc = 0;
        return r;
    endfunction

    task automatic chk(string name, int g, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cfg%0d (W=%0d S=%0d) got=%h exp=%h", name, g, wid(g), stg(g), got, exp);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge, when inputs and outputs are settled.
    int          cyc = 0;
    int          last_stall = -1;
    logic        prev_flush = 1'b0;
    logic        held_vld [4] = '{default: 1'b0};
    logic [63:0] held_imm [4];
    logic [63:0] held_tgt [4];
    logic        held_ill [4];
    logic        drain_req = 1'b0;
    logic        drain_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        cyc++;
        if (!rst_n) begin
            for (int g = 0; g < 4; g++) begin
                chk("rst_ovalid", g, 64'(o_vld[g]), 64'd0);
                chk("rst_imm", g, o_imm[g], 64'd0);
                chk("rst_tgt", g, o_tgt[g], 64'd0);
                chk("rst_ill", g, 64'(o_ill[g]), 64'd0);
                sbq[g].delete();
                held_vld[g] = 1'b0;
            end
            prev_flush = 1'b0;
        end else begin
            if (!out_ready) last_stall = cyc;
            for (int g = 0; g < 4; g++) begin
                chk("inready", g, 64'(o_rdy_in[g]),
                    64'(!flush && (out_ready || sbq[g].size() < stg(g))));
                if (prev_flush) chk("flush_kill", g, 64'(o_vld[g]), 64'd0);
                if (held_vld[g]) begin
                    chk("hold_vld", g, 64'(o_vld[g]), 64'd1);
                    chk("hold_imm", g, o_imm[g], held_imm[g]);
                    chk("hold_tgt", g, o_tgt[g], held_tgt[g]);
                    chk("hold_ill", g, 64'(o_ill[g]), 64'(held_ill[g]));
                end
                if (o_vld[g] && out_ready) begin
                    if (sbq[g].size() == 0) begin
                        chk("spurious_out", g, 64'd1, 64'd0);
                    end else begin
                        e   = sbq[g].pop_front();
                        lat = cyc - e.acc;
                        chk("imm", g, o_imm[g], e.imm);
                        chk("tgt", g, o_tgt[g], e.tgt);
                        chk("ill", g, 64'(o_ill[g]), 64'(e.ill));
                        if (e.acc > last_stall) chk("latency", g, 64'(lat), 64'(stg(g)));
                        else                    chk("latency_min", g, 64'(lat >= stg(g)), 64'd1);
                    end
                end
                if (flush) begin
                    sbq[g].delete();
                end else if (in_valid && o_rdy_in[g]) begin
                    e     = ref_calc(instr, imm_src, wid(g), pc);
                    e.acc = cyc;
                    sbq[g].push_back(e);
                end
                held_vld[g] = o_vld[g] && !out_ready && !flush;
                held_imm[g] = o_imm[g];
                held_tgt[g] = o_tgt[g];
                held_ill[g] = o_ill[g];
            end
            prev_flush = flush;
            if (drain_req && !drain_done) begin
                for (int g = 0; g < 4; g++) chk("drain_empty", g, 64'(sbq[g].size()), 64'd0);
                drain_done = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [31:0] i, imm_src_e s, logic [63:0] p);
        in_valid = 1'b1;
        instr    = i;
        imm_src  = s;
        pc       = p;
        step();
    endtask

    task automatic idle(int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_inputs();
        instr   = $urandom;
        imm_src = imm_src_e'($urandom_range(0, 7));
        pc      = {$urandom, $urandom};
    endtask

    initial begin
        // Reset held with random activity on every input.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            in_valid  = 1'($urandom);
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        idle(2);

        // Directed formats and boundaries, free-flowing output.
        put(32'hFFF00093, IMM_I, 64'h1000);
        put(32'h800000EF, IMM_J, 64'h1000);
        put(32'h000F8073, IMM_ZIMM, 64'h1000);
        put(32'h12345677, IMM_RSVD, 64'h1000);
        put(32'h80000037, IMM_U, 64'h10);
        put(32'h03F00013, IMM_SHAMT, 64'h10);
        put(32'h00800093, IMM_I, 64'h0000_0000_FFFF_FFFC);
        put(32'h00800093, IMM_I, 64'hFFFF_FFFF_FFFF_FFFC);
        put(32'hFE000FA3, IMM_S, 64'h2000);
        put(32'h80000063, IMM_B, 64'h2000);
        idle(4);

        // Backpressure: stream while the output is stalled, then release.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            put(instr, imm_src, pc);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b1;
        idle(5);

        // Flush with two entries in flight, then a new entry right after.
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            put(instr, imm_src, pc);
        end
        flush = 1'b1;
        rand_inputs();
        put(instr, imm_src, pc);
        flush = 1'b0;
        put(32'hFFF00093, IMM_I, 64'h1000);
        idle(4);

        // Flush while stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            put(instr, imm_src, pc);
        end
        flush = 1'b1;
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            rand_inputs();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 3);
            step();
        end
        flush = 1'b0;

        // Reset asserted in the middle of a stall.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            put(instr, imm_src, pc);
        end
        rst_n = 1'b0;
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        put(32'h00800093, IMM_I, 64'h0000_0000_FFFF_FFFC);
        idle(6);

        // Drain and confirm nothing remains outstanding.
        drain_req = 1'b1;
        for (int i = 0; i < 10 && !drain_done; i++) step();
        if (!drain_done) begin
            $display("FAIL drain_timeout monitor did not complete the drain check");
            bad++;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
